// File: rtl/eight_to_three_seq_encoder.sv
// eight_to_three_seq_encoder
//   Takes an 8-bit request vector over a valid/ready handshake. It then emits
//   the 3-bit index of each set bit, one index per output handshake, in fixed
//   priority order. An all-zero vector produces one beat flagged out_none.
//
// Parameters
//   MSB_FIRST  1: emit highest set index first; 0: emit lowest set index first
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_req is valid
//   in_ready   block is idle and can accept a vector
//   in_req     request vector, bit k = request k
//   out_valid  out_idx/out_last/out_none are valid
//   out_ready  consumer accepts the current beat
//   out_idx    binary index of the current set bit
//   out_last   current beat is the final beat for this vector
//   out_none   accepted vector was all-zero (single beat, out_idx = 0)
module eight_to_three_seq_encoder #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_idx,
    output logic       out_last,
    output logic       out_none
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic       none_q, none_d;

    // Output flops are loaded from the next-state values. The outputs therefore
    // describe the state being entered, with no combinational path from the
    // inputs to the outputs.
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] out_idx_q, out_idx_d;
    logic       out_last_q, out_last_d;
    logic       out_none_q, out_none_d;

    // Priority pick over a fixed 8 bits. In the MSB_FIRST case the ascending
    // loop lets the highest set bit win. In the other case the descending loop
    // lets the lowest set bit win.
    function automatic logic [2:0] pick_idx(input logic [7:0] vec);
        logic [2:0] idx;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] vec);
        return (vec != 8'h00) && ((vec & (vec - 8'h01)) == 8'h00);
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before the case. No path can leave
        // a signal unassigned, so no latch is inferred.
        state_d = state_q;
        pend_d  = pend_q;
        none_d  = none_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    pend_d  = in_req;
                    none_d  = (in_req == 8'h00);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        state_d = IDLE;
                        pend_d  = 8'h00;
                        none_d  = 1'b0;
                    end else begin
                        pend_d = pend_q & ~(8'h01 << out_idx_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 8'h00;
                none_d  = 1'b0;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
        out_idx_d   = pick_idx(pend_d);
        out_last_d  = (state_d == EMIT) && (none_d || is_onehot(pend_d));
        out_none_d  = (state_d == EMIT) && none_d;
    end

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // therefore update together on the edge, whatever order they are written in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pend_q      <= 8'h00;
            none_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            none_q      <= none_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            out_none_q  <= out_none_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;

endmodule

// File: tb/tb_eight_to_three_seq_encoder.sv
// Testbench for eight_to_three_seq_encoder.
// Two instances share all inputs: one emits MSB-first, the other LSB-first.
// For each vector, a reference model builds the list of expected indices from
// the set bits of the vector. Each beat of both instances is compared with
// that list.
module tb_eight_to_three_seq_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic       out_ready = 1'b0;

    logic       m_in_ready, m_out_valid, m_out_last, m_out_none;
    logic [2:0] m_out_idx;
    logic       l_in_ready, l_out_valid, l_out_last, l_out_none;
    logic [2:0] l_out_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eight_to_three_seq_encoder #(.MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (m_in_ready),
        .in_req    (in_req),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_idx   (m_out_idx),
        .out_last  (m_out_last),
        .out_none  (m_out_none)
    );

    eight_to_three_seq_encoder #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (l_in_ready),
        .in_req    (in_req),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .out_idx   (l_out_idx),
        .out_last  (l_out_last),
        .out_none  (l_out_none)
    );

    // Observed output bundle: {in_ready, out_valid, out_idx, out_last, out_none}
    wire [6:0] m_obs = {m_in_ready, m_out_valid, m_out_idx, m_out_last, m_out_none};
    wire [6:0] l_obs = {l_in_ready, l_out_valid, l_out_idx, l_out_last, l_out_none};

    // Reset must force every output except in_ready to zero.
    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (m_obs[5:0] !== 6'd0) begin
            n_err++;
            $display("FAIL %s msb: valid/idx/last/none got %b want 000000", tag, m_obs[5:0]);
        end
        n_vec++;
        if (l_obs[5:0] !== 6'd0) begin
            n_err++;
            $display("FAIL %s lsb: valid/idx/last/none got %b want 000000", tag, l_obs[5:0]);
        end
    endtask

    // Idle: ready to accept and no beat on the output.
    task automatic check_idle(input string tag);
        n_vec++;
        if (m_obs !== 7'b1_0_000_0_0) begin
            n_err++;
            $display("FAIL %s msb idle: got %b want 1000000", tag, m_obs);
        end
        n_vec++;
        if (l_obs !== 7'b1_0_000_0_0) begin
            n_err++;
            $display("FAIL %s lsb idle: got %b want 1000000", tag, l_obs);
        end
    endtask

    // Sends one vector and checks every beat on both instances.
    // mode 0: out_ready held high; 1: random out_ready; 2: out_ready low for
    // the first 3 cycles of EMIT, then high.
    task automatic send(input logic [7:0] v, input int mode, input string tag);
        int  exp_lsb[$];
        int  exp_msb[$];
        bit  none;
        int  k;
        int  stalls;
        logic [6:0] exp_m, exp_l;
        logic rdy;

        // Reference model: list the set bits in ascending order. The MSB-first
        // sequence is the same list reversed. An empty vector yields one none beat.
        for (int i = 0; i < 8; i++) begin
            if (v[i]) exp_lsb.push_back(i);
        end
        none = (exp_lsb.size() == 0);
        if (none) exp_lsb.push_back(0);
        for (int i = exp_lsb.size() - 1; i >= 0; i--) exp_msb.push_back(exp_lsb[i]);

        @(negedge clk);
        check_idle({tag, " pre-accept"});
        in_valid = 1'b1;
        in_req   = v;
        @(posedge clk);
        #1;
        // Inputs keep moving after the accept edge; the DUT must ignore them.
        in_valid = 1'($urandom);
        in_req   = 8'($urandom);

        k      = 0;
        stalls = 0;
        while (k < exp_lsb.size()) begin
            @(negedge clk);
            exp_m = {1'b0, 1'b1, 3'(exp_msb[k]), (k == exp_msb.size() - 1), none};
            exp_l = {1'b0, 1'b1, 3'(exp_lsb[k]), (k == exp_lsb.size() - 1), none};
            n_vec++;
            if (m_obs !== exp_m) begin
                n_err++;
                $display("FAIL %s msb beat %0d (v=%h): got rdy/vld/idx/last/none %b want %b",
                         tag, k, v, m_obs, exp_m);
            end
            n_vec++;
            if (l_obs !== exp_l) begin
                n_err++;
                $display("FAIL %s lsb beat %0d (v=%h): got rdy/vld/idx/last/none %b want %b",
                         tag, k, v, l_obs, exp_l);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = (stalls >= 3);
            endcase
            if (stalls >= 8) rdy = 1'b1;
            if (!rdy) stalls++;
            out_ready = rdy;
            in_valid  = 1'($urandom);
            in_req    = 8'($urandom);
            @(posedge clk);
            if (out_ready) k++;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_req    = 8'($urandom);
            out_ready = 1'($urandom);
            #1;
            check_reset_outputs("reset hold");
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle("reset release");
    endtask

    task automatic test_msb_a4();
        send(8'b1010_0100, 0, "pattern_a4");
    endtask

    task automatic test_all_ones();
        send(8'hFF, 0, "all_ones");
    endtask

    task automatic test_zero();
        send(8'h00, 0, "zero_vec");
    endtask

    task automatic test_backpressure();
        send(8'h81, 2, "backpressure");
    endtask

    task automatic test_back_to_back();
        send(8'h01, 0, "b2b_a");
        send(8'h80, 0, "b2b_b");
        send(8'h00, 1, "b2b_c");
        send(8'h3C, 1, "b2b_d");
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        in_valid  = 1'b1;
        in_req    = 8'hF0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (m_obs !== 7'b0_1_111_0_0) begin
            n_err++;
            $display("FAIL midrst msb first beat: got %b want 0111100", m_obs);
        end
        n_vec++;
        if (l_obs !== 7'b0_1_100_0_0) begin
            n_err++;
            $display("FAIL midrst lsb first beat: got %b want 0110000", l_obs);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst assert");
        repeat (2) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            in_req   = 8'($urandom);
            #1;
            check_reset_outputs("midrst hold");
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_idle("midrst no residual");
        end
        send(8'h01, 0, "midrst new");
    endtask

    task automatic test_random();
        repeat (40) send(8'($urandom), 1, "random");
    endtask

    initial begin
        test_reset();
        test_msb_a4();
        test_all_ones();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        @(negedge clk);
        check_idle("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Backstop in case a wait above never completes.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
